// File: rtl/dlx_ex_stage.sv
// DLX execute stage: operand select, ALU, branch resolve, EX->MEM pipeline register.
// Latency 1 cycle for single-cycle ops; MUL occupies EX for 32/MUL_RADIX_BITS+2 cycles.
// Backpressure: stall_EX holds IF/ID/ID->EX while the multiplier is busy (only with DLX_EX_MUL_EN).
// Build option: define DLX_EX_MUL_EN to include the iterative multiplier; otherwise opcode 15 yields 0.
module dlx_ex_stage #(
    parameter int MUL_RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        nullify,
    input  logic        d_write_enable_EX,
    input  logic        d_load_enable_EX,
    input  logic        Iv_alu_EX,
    input  logic        Pc_alu_EX,
    input  logic [4:0]  I_EX,
    input  logic [4:0]  Rd_EX,
    input  logic [31:0] Iv_EX,
    input  logic [31:0] S1_EX,
    input  logic [31:0] S2_EX,
    input  logic [31:0] PC_EX,
    output logic        pc_cmd_EX,
    output logic [31:0] pc_target_EX,
    output logic        stall_EX,
    output logic        d_write_enable_MEM,
    output logic        d_load_enable_MEM,
    output logic [4:0]  Rd_MEM,
    output logic [31:0] ALU_out_MEM,
    output logic [31:0] d_data_MEM
);

    generate
        if (MUL_RADIX_BITS != 1 && MUL_RADIX_BITS != 2 && MUL_RADIX_BITS != 4) begin : g_bad_radix
            $error("dlx_ex_stage: MUL_RADIX_BITS must be 1, 2 or 4");
        end
    endgenerate

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;

    // Multiplier handshake into the MEM register logic (constant when the multiplier is absent).
    logic        mul_hold;
    logic        mul_done;
    logic [4:0]  mul_rd;
    logic [31:0] mul_result;

    logic        we_mem_d, ld_mem_d;
    logic [4:0]  rd_mem_d;
    logic [31:0] alu_mem_d, data_mem_d;
    logic        we_mem_q, ld_mem_q;
    logic [4:0]  rd_mem_q;
    logic [31:0] alu_mem_q, data_mem_q;

    assign op_a = Pc_alu_EX ? PC_EX : S1_EX;
    assign op_b = Iv_alu_EX ? Iv_EX : S2_EX;

    // Branch condition tests the forwarded register operand, not the selected ALU input.
    assign pc_cmd_EX    = nullify & (((I_EX == 5'd12) & (S1_EX == 32'd0)) |
                                     ((I_EX == 5'd13) & (S1_EX != 32'd0)));
    assign pc_target_EX = PC_EX + Iv_EX;

    // Single-cycle ALU; branches, MUL and unused opcodes produce 0 here.
    always_comb begin
        alu_res = 32'd0;
        case (I_EX)
            5'd0:  alu_res = op_a + op_b;
            5'd1:  alu_res = op_a - op_b;
            5'd2:  alu_res = op_a & op_b;
            5'd3:  alu_res = op_a | op_b;
            5'd4:  alu_res = op_a ^ op_b;
            5'd5:  alu_res = op_a << op_b[4:0];
            5'd6:  alu_res = op_a >> op_b[4:0];
            5'd7:  alu_res = 32'($signed(op_a) >>> op_b[4:0]);
            5'd8:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            5'd9:  alu_res = {31'd0, op_a < op_b};
            5'd10: alu_res = {31'd0, op_a == op_b};
            5'd11: alu_res = {31'd0, op_a != op_b};
            5'd14: alu_res = {op_b[15:0], 16'h0000};
            default: alu_res = 32'd0;
        endcase
    end

`ifdef DLX_EX_MUL_EN
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int        MUL_STEPS = 32 / MUL_RADIX_BITS;
    localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

    mul_state_t  state_q, state_d;
    logic        mul_req, mul_start;
    logic [31:0] mul_a_q, mul_b_q, mul_acc_q, mul_pp;
    logic [4:0]  mul_cnt_q, mul_rd_q;

    assign mul_req = (I_EX == 5'd15) & ~nullify;

    // Multiplier state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= MUL_IDLE;
        else          state_q <= state_d;
    end

    // Multiplier next-state: IDLE -> BUSY for MUL_STEPS cycles -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (mul_req) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_cnt_q == LAST_STEP) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Multiplier outputs: stall from the accepting cycle through the last busy cycle.
    always_comb begin
        mul_start = 1'b0;
        mul_hold  = 1'b0;
        mul_done  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                mul_start = mul_req;
                mul_hold  = mul_req;
            end
            MUL_BUSY: mul_hold = 1'b1;
            MUL_DONE: mul_done = 1'b1;
            default:  mul_hold = 1'b0;
        endcase
    end

    // Partial product of the shifted multiplicand and the next multiplier digit.
    assign mul_pp = mul_a_q * {{(32 - MUL_RADIX_BITS){1'b0}}, mul_b_q[MUL_RADIX_BITS-1:0]};

    // Shift-and-add datapath: multiplicand moves left, multiplier right, one digit per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            mul_acc_q <= 32'd0;
            mul_cnt_q <= 5'd0;
            mul_rd_q  <= 5'd0;
        end else if (mul_start) begin
            mul_a_q   <= op_a;
            mul_b_q   <= op_b;
            mul_acc_q <= 32'd0;
            mul_cnt_q <= 5'd0;
            mul_rd_q  <= Rd_EX;
        end else if (state_q == MUL_BUSY) begin
            mul_a_q   <= mul_a_q << MUL_RADIX_BITS;
            mul_b_q   <= mul_b_q >> MUL_RADIX_BITS;
            mul_acc_q <= mul_acc_q + mul_pp;
            mul_cnt_q <= mul_cnt_q + 5'd1;
        end
    end

    // Reset gates the stall directly so ID is released in the reset cycle itself.
    assign stall_EX   = reset_n & mul_hold;
    assign mul_rd     = mul_rd_q;
    assign mul_result = mul_acc_q;
`else
    assign mul_hold   = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_rd     = 5'd0;
    assign mul_result = 32'd0;
    assign stall_EX   = 1'b0;
`endif

    // EX->MEM next state: bubble for branches and multiplier wait, product on completion.
    always_comb begin
        rd_mem_d   = Rd_EX;
        we_mem_d   = d_write_enable_EX;
        ld_mem_d   = d_load_enable_EX;
        data_mem_d = S2_EX;
        // r0 must read back as 0 through forwarding; memory ops still need the address.
        alu_mem_d  = ((Rd_EX == 5'd0) && !(d_write_enable_EX || d_load_enable_EX)) ? 32'd0 : alu_res;
        if (mul_done) begin
            rd_mem_d  = mul_rd;
            we_mem_d  = 1'b0;
            ld_mem_d  = 1'b0;
            alu_mem_d = (mul_rd == 5'd0) ? 32'd0 : mul_result;
        end else if (nullify || mul_hold) begin
            rd_mem_d   = 5'd0;
            we_mem_d   = 1'b0;
            ld_mem_d   = 1'b0;
            alu_mem_d  = 32'd0;
            data_mem_d = 32'd0;
        end
    end

    // EX->MEM pipeline register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_mem_q   <= 5'd0;
            we_mem_q   <= 1'b0;
            ld_mem_q   <= 1'b0;
            alu_mem_q  <= 32'd0;
            data_mem_q <= 32'd0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            we_mem_q   <= we_mem_d;
            ld_mem_q   <= ld_mem_d;
            alu_mem_q  <= alu_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    assign Rd_MEM             = rd_mem_q;
    assign d_write_enable_MEM = we_mem_q;
    assign d_load_enable_MEM  = ld_mem_q;
    assign ALU_out_MEM        = alu_mem_q;
    assign d_data_MEM         = data_mem_q;

endmodule

// File: tb/tb_dlx_ex_stage.sv
// Testbench for dlx_ex_stage: directed vector table, random vectors against a reference model,
// and multi-cycle multiplier sequences when DLX_EX_MUL_EN is defined.
module tb_dlx_ex_stage;

    localparam int RADIX     = 1;
    localparam int MUL_STEPS = 32 / RADIX;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, nullify, d_write_enable_EX, d_load_enable_EX, Iv_alu_EX, Pc_alu_EX;
    logic [4:0]  I_EX, Rd_EX;
    logic [31:0] Iv_EX, S1_EX, S2_EX, PC_EX;
    logic        pc_cmd_EX, stall_EX, d_write_enable_MEM, d_load_enable_MEM;
    logic [31:0] pc_target_EX, ALU_out_MEM, d_data_MEM;
    logic [4:0]  Rd_MEM;

    dlx_ex_stage #(.MUL_RADIX_BITS(RADIX)) dut (
        .clk(clk), .reset_n(reset_n), .nullify(nullify),
        .d_write_enable_EX(d_write_enable_EX), .d_load_enable_EX(d_load_enable_EX),
        .Iv_alu_EX(Iv_alu_EX), .Pc_alu_EX(Pc_alu_EX), .I_EX(I_EX), .Rd_EX(Rd_EX),
        .Iv_EX(Iv_EX), .S1_EX(S1_EX), .S2_EX(S2_EX), .PC_EX(PC_EX),
        .pc_cmd_EX(pc_cmd_EX), .pc_target_EX(pc_target_EX), .stall_EX(stall_EX),
        .d_write_enable_MEM(d_write_enable_MEM), .d_load_enable_MEM(d_load_enable_MEM),
        .Rd_MEM(Rd_MEM), .ALU_out_MEM(ALU_out_MEM), .d_data_MEM(d_data_MEM)
    );

    typedef struct {
        logic        nul, we, ld, iva, pca;
        logic [4:0]  op, rd;
        logic [31:0] iv, s1, s2, pc;
        logic        e_cmd;
        logic [31:0] e_tgt;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic        e_we, e_ld;
        logic [31:0] e_dat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic nul, we, ld, iva, pca, input logic [4:0] op, rd,
                                input logic [31:0] iv, s1, s2, pc,
                                input logic e_cmd, input logic [31:0] e_tgt, input logic [4:0] e_rd,
                                input logic [31:0] e_alu, input logic e_we, e_ld,
                                input logic [31:0] e_dat);
        vec_t v;
        v.nul = nul; v.we = we; v.ld = ld; v.iva = iva; v.pca = pca;
        v.op = op; v.rd = rd; v.iv = iv; v.s1 = s1; v.s2 = s2; v.pc = pc;
        v.e_cmd = e_cmd; v.e_tgt = e_tgt; v.e_rd = e_rd; v.e_alu = e_alu;
        v.e_we = e_we; v.e_ld = e_ld; v.e_dat = e_dat;
        return v;
    endfunction

    // Reference model: expected EX outputs straight from the instruction semantics.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] a, b, res;
        logic [63:0] ext;
        int          sh;
        r   = v;
        a   = v.pca ? v.pc : v.s1;
        b   = v.iva ? v.iv : v.s2;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a};
        case (v.op)
            5'd0:  res = a + b;
            5'd1:  res = a - b;
            5'd2:  res = a & b;
            5'd3:  res = a | b;
            5'd4:  res = a ^ b;
            5'd5:  res = a << sh;
            5'd6:  res = a >> sh;
            5'd7:  begin ext = ext >> sh; res = ext[31:0]; end
            5'd8:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  res = (a < b) ? 32'd1 : 32'd0;
            5'd10: res = (a == b) ? 32'd1 : 32'd0;
            5'd11: res = (a != b) ? 32'd1 : 32'd0;
            5'd14: res = {b[15:0], 16'h0000};
            default: res = 32'd0;
        endcase
        r.e_cmd = v.nul && ((v.op == 5'd12 && v.s1 == 32'd0) || (v.op == 5'd13 && v.s1 != 32'd0));
        r.e_tgt = v.pc + v.iv;
        if (v.nul) begin
            r.e_rd = 5'd0; r.e_alu = 32'd0; r.e_we = 1'b0; r.e_ld = 1'b0; r.e_dat = 32'd0;
        end else begin
            r.e_rd  = v.rd;
            r.e_we  = v.we;
            r.e_ld  = v.ld;
            r.e_dat = v.s2;
            r.e_alu = (v.rd == 5'd0 && !v.we && !v.ld) ? 32'd0 : res;
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        nullify = v.nul; d_write_enable_EX = v.we; d_load_enable_EX = v.ld;
        Iv_alu_EX = v.iva; Pc_alu_EX = v.pca; I_EX = v.op; Rd_EX = v.rd;
        Iv_EX = v.iv; S1_EX = v.s1; S2_EX = v.s2; PC_EX = v.pc;
    endtask

    task automatic drive_nop();
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0));
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, ".pc_cmd"}, {31'd0, pc_cmd_EX}, {31'd0, v.e_cmd});
        check({tag, ".pc_target"}, pc_target_EX, v.e_tgt);
        check({tag, ".stall"}, {31'd0, stall_EX}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".rd_mem"}, {27'd0, Rd_MEM}, {27'd0, v.e_rd});
        check({tag, ".alu_mem"}, ALU_out_MEM, v.e_alu);
        check({tag, ".we_mem"}, {31'd0, d_write_enable_MEM}, {31'd0, v.e_we});
        check({tag, ".ld_mem"}, {31'd0, d_load_enable_MEM}, {31'd0, v.e_ld});
        check({tag, ".data_mem"}, d_data_MEM, v.e_dat);
    endtask

`ifdef DLX_EX_MUL_EN
    // Issue one MUL, count stall cycles, confirm bubbles meanwhile and the product afterwards.
    task automatic run_mul(input logic [31:0] a, b, input logic [4:0] rd, input string tag);
        int   cyc;
        logic dirty;
        logic [31:0] prod;
        prod = a * b;
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, rd, 32'd0, a, b, 32'd0,
                 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0));
        #1;
        cyc   = 0;
        dirty = 1'b0;
        while (stall_EX === 1'b1 && cyc < 200) begin
            cyc++;
            if (pc_cmd_EX !== 1'b0) dirty = 1'b1;
            @(posedge clk);
            #1;
            if (Rd_MEM !== 5'd0 || ALU_out_MEM !== 32'd0 || d_write_enable_MEM !== 1'b0) dirty = 1'b1;
        end
        check({tag, ".stall_cycles"}, 32'(cyc), 32'(MUL_STEPS + 1));
        check({tag, ".bubbles"}, {31'd0, dirty}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".rd_mem"}, {27'd0, Rd_MEM}, {27'd0, rd});
        check({tag, ".product"}, ALU_out_MEM, (rd == 5'd0) ? 32'd0 : prod);
        drive_nop();
        #1;
        check({tag, ".stall_after"}, {31'd0, stall_EX}, 32'd0);
    endtask
`endif

    vec_t tbl[16];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0,0,0,1,0, 5'd0,  5'd5, 32'hFFFFFFFD, 32'd7, 32'd0, 32'd0,      0, 32'hFFFFFFFD, 5'd5, 32'd4, 0,0, 32'd0);
        tbl[1]  = mk(1,0,0,1,0, 5'd12, 5'd0, 32'h40, 32'd0, 32'd0, 32'h100,          1, 32'h140, 5'd0, 32'd0, 0,0, 32'd0);
        tbl[2]  = mk(1,0,0,1,0, 5'd12, 5'd0, 32'h40, 32'd1, 32'd0, 32'h100,          0, 32'h140, 5'd0, 32'd0, 0,0, 32'd0);
        tbl[3]  = mk(0,0,0,0,0, 5'd0,  5'd0, 32'd0, 32'd9, 32'd1, 32'd0,             0, 32'd0, 5'd0, 32'd0, 0,0, 32'd1);
        tbl[4]  = mk(0,1,0,1,0, 5'd0,  5'd0, 32'd4, 32'h20, 32'hDEAD, 32'd0,         0, 32'd4, 5'd0, 32'h24, 1,0, 32'hDEAD);
        tbl[5]  = mk(0,0,0,0,0, 5'd7,  5'd1, 32'd0, 32'h80000000, 32'd4, 32'd0,      0, 32'd0, 5'd1, 32'hF8000000, 0,0, 32'd4);
        tbl[6]  = mk(0,0,0,0,0, 5'd8,  5'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0,      0, 32'd0, 5'd2, 32'd1, 0,0, 32'd0);
        tbl[7]  = mk(0,0,0,0,0, 5'd9,  5'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0,      0, 32'd0, 5'd2, 32'd0, 0,0, 32'd0);
        tbl[8]  = mk(0,0,0,1,0, 5'd14, 5'd4, 32'h1234, 32'd0, 32'd0, 32'd0,          0, 32'h1234, 5'd4, 32'h12340000, 0,0, 32'd0);
        tbl[9]  = mk(1,0,0,1,0, 5'd13, 5'd0, 32'hFFFFFFF8, 32'd5, 32'd0, 32'h200,    1, 32'h1F8, 5'd0, 32'd0, 0,0, 32'd0);
        tbl[10] = mk(0,0,0,1,1, 5'd0,  5'd31, 32'd8, 32'd0, 32'd0, 32'h1000,         0, 32'h1008, 5'd31, 32'h1008, 0,0, 32'd0);
        tbl[11] = mk(0,0,1,1,0, 5'd0,  5'd0, 32'h10, 32'h40, 32'd0, 32'd0,           0, 32'h10, 5'd0, 32'h50, 0,1, 32'd0);
        tbl[12] = mk(0,0,0,0,0, 5'd20, 5'd6, 32'd0, 32'hFFFF, 32'd3, 32'd0,          0, 32'd0, 5'd6, 32'd0, 0,0, 32'd3);
        tbl[13] = mk(0,0,0,0,0, 5'd10, 5'd7, 32'd0, 32'd5, 32'd5, 32'd0,             0, 32'd0, 5'd7, 32'd1, 0,0, 32'd5);
        tbl[14] = mk(0,0,0,0,0, 5'd11, 5'd7, 32'd0, 32'd5, 32'd5, 32'd0,             0, 32'd0, 5'd7, 32'd0, 0,0, 32'd5);
        tbl[15] = mk(0,0,0,0,0, 5'd1,  5'd8, 32'd0, 32'd3, 32'd5, 32'd0,             0, 32'd0, 5'd8, 32'hFFFFFFFE, 0,0, 32'd5);

        // Reset held for two cycles.
        reset_n = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst.rd_mem", {27'd0, Rd_MEM}, 32'd0);
        check("rst.alu_mem", ALU_out_MEM, 32'd0);
        check("rst.we_mem", {31'd0, d_write_enable_MEM}, 32'd0);
        check("rst.ld_mem", {31'd0, d_load_enable_MEM}, 32'd0);
        check("rst.data_mem", d_data_MEM, 32'd0);
        check("rst.stall", {31'd0, stall_EX}, 32'd0);
        check("rst.pc_cmd", {31'd0, pc_cmd_EX}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 16; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

`ifdef DLX_EX_MUL_EN
        run_mul(32'd6, 32'd7, 5'd3, "mul6x7");

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 5'd3, 32'd0, 32'd6, 32'd7, 32'd0,
                 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0));
        repeat (10) @(posedge clk);
        #1;
        check("mulrst.busy_stall", {31'd0, stall_EX}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mulrst.stall_drop", {31'd0, stall_EX}, 32'd0);
        @(posedge clk);
        #1;
        check("mulrst.rd_mem", {27'd0, Rd_MEM}, 32'd0);
        check("mulrst.alu_mem", ALU_out_MEM, 32'd0);
        check("mulrst.stall", {31'd0, stall_EX}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_nop();
        @(posedge clk);
        #1;
        check("mulrst.stall_idle", {31'd0, stall_EX}, 32'd0);
        check("mulrst.alu_idle", ALU_out_MEM, 32'd0);

        run_mul(32'd5, 32'd9, 5'd7, "mul_after_rst");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, "mul_wrap");
        run_mul(32'd1234, 32'd5678, 5'd0, "mul_r0");
        for (int k = 0; k < 3; k++)
            run_mul($urandom(), $urandom(), 5'($urandom_range(1, 31)), $sformatf("mul_rand%0d", k));
`else
        // Without the multiplier, opcode 15 is an ordinary single-cycle op yielding 0.
        apply_vec(mk(0,0,0,0,0, 5'd15, 5'd3, 32'd0, 32'd6, 32'd7, 32'd0,
                     0, 32'd0, 5'd3, 32'd0, 0,0, 32'd7), "mul_off");
`endif

        // Random vectors against the reference model.
        for (int n = 0; n < 300; n++) begin
            rv.nul = ($urandom_range(0, 3) == 0);
            rv.op  = rv.nul ? (($urandom_range(0, 1) == 0) ? 5'd12 : 5'd13) : 5'($urandom_range(0, 31));
`ifdef DLX_EX_MUL_EN
            if (!rv.nul && rv.op == 5'd15) rv.op = 5'd0;
`endif
            rv.we  = ($urandom_range(0, 7) == 0);
            rv.ld  = !rv.we && ($urandom_range(0, 7) == 0);
            rv.iva = 1'($urandom_range(0, 1));
            rv.pca = ($urandom_range(0, 3) == 0);
            rv.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rv.iv  = $urandom();
            rv.s1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            rv.s2  = ($urandom_range(0, 7) == 0) ? rv.s1 : $urandom();
            rv.pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            apply_vec(model(rv), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
